// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming [7,4] encoder/decoder pair.
// Holds the codeword bit layout, the stage-2 result payload and the
// syndrome-to-position map.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYND_W = 3;
  localparam int unsigned POS_W  = 3;

  // Codeword bit positions: {d3,d2,d1,d0,p0,p1,p2}
  localparam int unsigned IDX_D3 = 6;
  localparam int unsigned IDX_D2 = 5;
  localparam int unsigned IDX_D1 = 4;
  localparam int unsigned IDX_D0 = 3;
  localparam int unsigned IDX_P0 = 2;
  localparam int unsigned IDX_P1 = 1;
  localparam int unsigned IDX_P2 = 0;

  // Decoded word as held in the output stage
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err_detected;
    logic [POS_W-1:0]  err_pos;
  } dec_result_t;

  // Maps syndrome {s2,s1,s0} to the index of the flipped bit; 0 for no error.
  function automatic logic [POS_W-1:0] syndrome_to_pos(input logic [SYND_W-1:0] s);
    logic [POS_W-1:0] pos;
    pos = '0;
    case (s)
      3'b101:  pos = POS_W'(IDX_D3);
      3'b110:  pos = POS_W'(IDX_D2);
      3'b011:  pos = POS_W'(IDX_D1);
      3'b111:  pos = POS_W'(IDX_D0);
      3'b001:  pos = POS_W'(IDX_P0);
      3'b010:  pos = POS_W'(IDX_P1);
      3'b100:  pos = POS_W'(IDX_P2);
      default: pos = '0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and error-position computation for one codeword.
// Ports:
//   codeword_i  received 7-bit word in encoder layout
//   syndrome_c  {s2,s1,s0}, zero for a clean word
//   pos_c       index of the bit to flip (0 when syndrome is zero)
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] codeword_i,
  output logic [SYND_W-1:0] syndrome_c,
  output logic [POS_W-1:0]  pos_c
);

  logic s0_c, s1_c, s2_c;

  // Each syndrome bit re-checks one parity bit against the data it covers
  assign s0_c = codeword_i[IDX_P0] ^ codeword_i[IDX_D3] ^ codeword_i[IDX_D1] ^ codeword_i[IDX_D0];
  assign s1_c = codeword_i[IDX_P1] ^ codeword_i[IDX_D2] ^ codeword_i[IDX_D1] ^ codeword_i[IDX_D0];
  assign s2_c = codeword_i[IDX_P2] ^ codeword_i[IDX_D3] ^ codeword_i[IDX_D2] ^ codeword_i[IDX_D0];

  assign syndrome_c = {s2_c, s1_c, s0_c};
  assign pos_c      = syndrome_to_pos(syndrome_c);

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage pipelined Hamming [7,4] single-error-correcting decoder with
// valid/ready handshakes and a saturating corrected-error counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready is combinational)
//   codeword                 received word {d3,d2,d1,d0,p0,p1,p2}
//   out_valid/out_ready      output handshake
//   data, err_detected,      corrected data and correction status
//   err_pos
//   err_count, count_clear   saturating corrected-word counter and its clear
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   codeword,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   data,
  output logic                err_detected,
  output logic [POS_W-1:0]    err_pos,
  output logic [COUNT_W-1:0]  err_count,
  input  logic                count_clear
);

  logic [SYND_W-1:0]  syn_c;
  logic [POS_W-1:0]   pos_c;

  logic               v1_q, v1_d;
  logic [CODE_W-1:0]  cw1_q, cw1_d;
  logic [SYND_W-1:0]  syn1_q, syn1_d;
  logic [POS_W-1:0]   pos1_q, pos1_d;

  logic               v2_q, v2_d;
  dec_result_t        res_q, res_d;

  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               ld1_c, ld2_c;
  logic [CODE_W-1:0]  mask_c;
  logic [CODE_W-1:0]  fixed_c;

  hamming_syndrome u_syndrome (
    .codeword_i (codeword),
    .syndrome_c (syn_c),
    .pos_c      (pos_c)
  );

  // Stage advance: a stage may load when it is empty or its successor drains
  assign ld2_c    = !v2_q || out_ready;
  assign ld1_c    = !v1_q || ld2_c;
  assign in_ready = ld1_c;

  // Correction mask is only applied for a non-zero syndrome
  assign mask_c  = (syn1_q != '0) ? (CODE_W'(1) << pos1_q) : '0;
  assign fixed_c = cw1_q ^ mask_c;

  // Next-state for both pipeline stages and the counter
  always_comb begin
    v1_d   = v1_q;
    cw1_d  = cw1_q;
    syn1_d = syn1_q;
    pos1_d = pos1_q;
    v2_d   = v2_q;
    res_d  = res_q;
    cnt_d  = cnt_q;

    if (ld1_c) begin
      v1_d = in_valid;
      if (in_valid) begin
        cw1_d  = codeword;
        syn1_d = syn_c;
        pos1_d = pos_c;
      end
    end

    if (ld2_c) begin
      v2_d = v1_q;
      if (v1_q) begin
        res_d.data         = fixed_c[IDX_D3:IDX_D0];
        res_d.err_detected = (syn1_q != '0);
        res_d.err_pos      = (syn1_q != '0) ? pos1_q : '0;
      end
    end

    // Clear wins over a coincident increment
    if (count_clear) begin
      cnt_d = '0;
    end else if (v2_q && out_ready && res_q.err_detected && (cnt_q != '1)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      cw1_q  <= '0;
      syn1_q <= '0;
      pos1_q <= '0;
      v2_q   <= 1'b0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      cw1_q  <= cw1_d;
      syn1_q <= syn1_d;
      pos1_q <= pos1_d;
      v2_q   <= v2_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid    = v2_q;
  assign data         = res_q.data;
  assign err_detected = res_q.err_detected;
  assign err_pos      = res_q.err_pos;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: the driver pushes hand-derived
// expected results on each accepted word, the monitor pops on each output
// transfer. A second instance with a 4-bit counter exercises saturation.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, in_ready4;
  logic [6:0] codeword;
  logic       out_valid, out_valid4;
  logic       out_ready;
  logic [3:0] data, data4;
  logic       err_detected, err_detected4;
  logic [2:0] err_pos, err_pos4;
  logic [15:0] err_count;
  logic [3:0] err_count4;
  logic       count_clear;

  always #5 clk = ~clk;

  hamming_decoder #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
    .data(data), .err_detected(err_detected), .err_pos(err_pos),
    .err_count(err_count), .count_clear(count_clear)
  );

  hamming_decoder #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .codeword(codeword), .out_valid(out_valid4), .out_ready(out_ready),
    .data(data4), .err_detected(err_detected4), .err_pos(err_pos4),
    .err_count(err_count4), .count_clear(count_clear)
  );

  typedef struct {
    logic [3:0] d;
    logic       det;
    logic [2:0] pos;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Hand-computed encoder outputs for data 0..F
  logic [6:0] enc_tab [16] = '{7'h00, 7'h0F, 7'h16, 7'h19, 7'h23, 7'h2C, 7'h35, 7'h3A,
                               7'h45, 7'h4A, 7'h53, 7'h5C, 7'h66, 7'h69, 7'h70, 7'h7F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard compare on transfers, stability check while stalled
  logic       hold_pend = 1'b0;
  logic [3:0] hold_d;
  logic       hold_det;
  logic [2:0] hold_pos;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", {hold_det, hold_pos, hold_d}, {err_detected, err_pos, data});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", 32'(data), 32'(e.d));
          chk("err_detected", 32'(err_detected), 32'(e.det));
          chk("err_pos", 32'(err_pos), 32'(e.pos));
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_d    = data;
      hold_det  = err_detected;
      hold_pos  = err_pos;
    end
  end

  // Present one word until accepted; expectation is pushed on acceptance
  task automatic send(input logic [6:0] cw, input logic [3:0] ed, input logic edet,
                      input logic [2:0] epos, input bit rnd);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    codeword = cw;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back('{d: ed, det: edet, pos: epos});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; codeword = '0; out_ready = 1'b1; count_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_err", {err_detected, err_pos}, 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Two-cycle latency on an idle pipeline
    send(enc_tab[0], 4'h0, 1'b0, 3'd0, 1'b0);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(out_valid), 32'd1);

    // Clean words, back-to-back
    for (int d = 0; d < 16; d++) send(enc_tab[d], 4'(d), 1'b0, 3'd0, 1'b0);
    drain();
    chk("clean_count", 32'(err_count), 32'd0);

    // Every single-bit error
    for (int d = 0; d < 16; d++)
      for (int b = 0; b < 7; b++)
        send(enc_tab[d] ^ (7'd1 << b), 4'(d), 1'b1, 3'(b), 1'b0);
    drain();
    chk("single_count", 32'(err_count), 32'd112);
    chk("sat_count", 32'(err_count4), 32'd15);

    // Double error 0x5C^{6,5}: syndrome 101^110=011 -> bit 4 flipped -> 0x2C, data 5
    send(7'h3C, 4'h5, 1'b1, 3'd4, 1'b0);
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready drops
    out_ready = 1'b0;
    send(enc_tab[1], 4'h1, 1'b0, 3'd0, 1'b0);
    send(enc_tab[2] ^ 7'h01, 4'h2, 1'b1, 3'd0, 1'b0);
    in_valid = 1'b1;
    codeword = enc_tab[3];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    send(enc_tab[3], 4'h3, 1'b0, 3'd0, 1'b1);
    send(enc_tab[4] ^ 7'h40, 4'h4, 1'b1, 3'd6, 1'b1);
    send(enc_tab[5], 4'h5, 1'b0, 3'd0, 1'b1);
    send(enc_tab[6] ^ 7'h08, 4'h6, 1'b1, 3'd3, 1'b1);
    send(enc_tab[7], 4'h7, 1'b0, 3'd0, 1'b1);
    send(enc_tab[8] ^ 7'h04, 4'h8, 1'b1, 3'd2, 1'b1);
    drain();

    // Clear coincident with an errored output transfer
    out_ready = 1'b0;
    send(7'h7C, 4'hB, 1'b1, 3'd5, 1'b0);
    @(posedge clk); #1;
    chk("clr_setup_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; count_clear = 1'b1;
    @(posedge clk); #1;
    count_clear = 1'b0;
    chk("clr_count", 32'(err_count), 32'd0);
    chk("clr_count4", 32'(err_count4), 32'd0);

    // Saturation again from zero with 20 errored words
    for (int i = 0; i < 20; i++) send(enc_tab[i % 16] ^ 7'h10, 4'(i % 16), 1'b1, 3'd4, 1'b0);
    drain();
    chk("sat20_count4", 32'(err_count4), 32'd15);
    chk("sat20_count", 32'(err_count), 32'd20);

    // Reset with both stages full
    out_ready = 1'b0;
    send(enc_tab[9], 4'h9, 1'b0, 3'd0, 1'b0);
    send(enc_tab[10] ^ 7'h02, 4'hA, 1'b1, 3'd1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;

    // Pipeline works again after reset
    send(enc_tab[12], 4'hC, 1'b0, 3'd0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
